icache_boot_ctrl: RTL
=====================

ICACHE_BOOT_CTRL -- requirements
Module: icache_boot_ctrl

Interface
REQ-001 The block SHALL provide ports: clk  input  1  single clock for all logic.
REQ-002 The block SHALL provide: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 The block SHALL provide: start  input  1  one-cycle request to begin a boot load.
REQ-004 The block SHALL provide: word_cnt  input  9  number of instruction words to load, sampled when start is accepted.
REQ-005 The block SHALL provide: in_valid  input  1  the source presents a word on in_data.
REQ-006 The block SHALL provide: in_data  input  32  instruction or checksum word.
REQ-007 The block SHALL provide: in_ready  output  1  the block accepts in_data this cycle.
REQ-008 The block SHALL provide: boot_addr  output  8  icache write address.
REQ-009 The block SHALL provide: boot_datai  output  32  icache write data.
REQ-010 The block SHALL provide: boot_web  output  1  icache write enable, active-low.
REQ-011 The block SHALL provide: boot_up  output  1  holds the PC in boot; high = CPU halted.
REQ-012 The block SHALL provide: boot_done  output  1  load completed successfully.
REQ-013 The block SHALL provide: boot_err  output  1  checksum mismatch; tied 0 when the checksum is not compiled in.

Function
REQ-014 The FSM SHALL use the states IDLE, LOAD, CHECK (only when the checksum is compiled in), DONE and ERR.
REQ-015 In IDLE, DONE or ERR, start=1 SHALL latch the effective count, clear the address counter and enter LOAD next cycle; boot_up=1 and boot_done=0 from that cycle.
REQ-016 Effective count: word_cnt=0 SHALL go straight to DONE with no writes; word_cnt>256 SHALL be clamped to 256.
REQ-017 start SHALL be ignored in LOAD and CHECK.
REQ-018 in_ready SHALL be 1 exactly in LOAD and CHECK; a transfer occurs only when in_valid and in_ready are both 1.
REQ-019 A LOAD transfer in cycle t SHALL produce registered boot_web=0 in cycle t+1, with boot_addr=address counter and boot_datai=in_data from cycle t; otherwise boot_web=1.
REQ-020 The address counter SHALL increment by 1 per LOAD transfer, starting at 0 and reaching at most 255, with no wrap.
REQ-021 The transfer of the last counted word SHALL move the FSM to CHECK, or to DONE when the checksum is not compiled in.
REQ-022 When DONE is entered, in that cycle (t+2 after the last transfer) boot_up SHALL go to 0 and boot_done to 1, both held until the next start.
REQ-023 in_valid stalls SHALL insert idle cycles without a write and without changing state.

Reset
REQ-024 While rst_n=0, the block SHALL be in IDLE, with boot_up=1, boot_web=1, in_ready=0, boot_done=0, boot_err=0, boot_addr=0, boot_datai=0 and the counters cleared.
REQ-025 A reset during LOAD or CHECK SHALL abandon the load; the icache contents are then undefined and the CPU SHALL stay halted until a new load completes.

Configuration
REQ-026 When the macro BOOT_CKSUM_EN is defined, the block SHALL keep a 32-bit sum, mod 2^32, of all loaded words and SHALL accept one extra word in CHECK.
REQ-027 With BOOT_CKSUM_EN defined, the CHECK word SHALL NOT be written to the icache; a match SHALL lead to DONE and a mismatch to ERR.
REQ-028 In ERR, the block SHALL hold boot_err=1, boot_up=1 and boot_done=0 until start or reset.
REQ-029 With BOOT_CKSUM_EN defined and word_cnt=0, the block SHALL still enter CHECK, with an expected sum of 0.
REQ-030 Without BOOT_CKSUM_EN, there SHALL be no CHECK state and no sum logic, and boot_err SHALL be constant 0.

Structure
REQ-031 A shared package boot_ctrl_pkg SHALL hold the FSM state enum, ICACHE_DEPTH=256, ICACHE_AW=8 and ICACHE_DW=32.
REQ-032 The sum register and compare logic SHALL be a single sub-module, boot_cksum, instantiated only under BOOT_CKSUM_EN.
REQ-033 All outputs SHALL be registered; the block SHALL drive the icache boot_addr/boot_datai/boot_web ports and the PC boot_up input directly.

Verification
REQ-034 The bench SHALL cover: start, word_cnt=4, in_valid constant 1 with words 0x11,0x22,0x33,0x44 -> writes to addresses 0..3 in four consecutive cycles, then boot_up=0 and boot_done=1 two cycles after the last transfer.
REQ-035 The bench SHALL cover: word_cnt=3 with in_valid toggled 1,0,1,0,1 -> exactly three boot_web=0 pulses, at addresses 0,1,2, with no write on stall cycles.
REQ-036 The bench SHALL cover: word_cnt=300 -> exactly 256 writes, the last at address 0xFF, then DONE.
REQ-037 The bench SHALL cover: word_cnt=0 -> DONE one cycle after start with no write; under BOOT_CKSUM_EN, checksum word 0 -> DONE and checksum word 1 -> ERR.
REQ-038 The bench SHALL cover: BOOT_CKSUM_EN, words 0xFFFFFFFF,0x00000002 and checksum 0x00000001 -> DONE; the same words with checksum 0x00000002 -> boot_err=1 and boot_up held 1.
REQ-039 The bench SHALL cover: rst_n pulled low after the second word of an 8-word load -> all outputs at reset values immediately; a new start reloads from address 0.

Source files
------------

// File: rtl/boot_ctrl_pkg.sv
// rtl/boot_ctrl_pkg.sv - shared FSM states and icache geometry for the boot loader (CHECK exists only with BOOT_CKSUM_EN)
package boot_ctrl_pkg;

    localparam int ICACHE_DEPTH = 256;
    localparam int ICACHE_AW    = 8;
    localparam int ICACHE_DW    = 32;
    localparam int CNT_W        = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
`ifdef BOOT_CKSUM_EN
        CHECK = 3'd2,
`endif
        DONE  = 3'd3,
        ERR   = 3'd4
    } boot_state_e;

endpackage

// File: rtl/boot_cksum.sv
// rtl/boot_cksum.sv - running mod-2^32 sum of loaded words and compare against the trailing checksum word
module boot_cksum
    import boot_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 add_i,
    input  logic [ICACHE_DW-1:0] data_i,
    output logic                 match_o
);

    logic [ICACHE_DW-1:0] sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (clr_i) begin
            sum_q <= '0;
        end else if (add_i) begin
            sum_q <= sum_q + data_i;
        end
    end

    // Compared against the word currently on the input, i.e. the checksum word while in CHECK.
    assign match_o = (sum_q == data_i);

endmodule

// File: rtl/icache_boot_ctrl.sv
// rtl/icache_boot_ctrl.sv - streams boot words into the icache and holds the CPU until loaded (optional BOOT_CKSUM_EN)
module icache_boot_ctrl
    import boot_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     word_cnt,
    input  logic                 in_valid,
    input  logic [ICACHE_DW-1:0] in_data,
    output logic                 in_ready,
    output logic [ICACHE_AW-1:0] boot_addr,
    output logic [ICACHE_DW-1:0] boot_datai,
    output logic                 boot_web,
    output logic                 boot_up,
    output logic                 boot_done,
    output logic                 boot_err
);

    localparam logic [CNT_W-1:0]     MAX_CNT   = CNT_W'(ICACHE_DEPTH);
    localparam logic [ICACHE_AW-1:0] LAST_ADDR = {ICACHE_AW{1'b1}};

    boot_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [ICACHE_AW-1:0] addr_cnt_q;
    logic                 in_ready_q;
    logic [ICACHE_AW-1:0] boot_addr_q;
    logic [ICACHE_DW-1:0] boot_datai_q;
    logic                 boot_web_q;
    logic                 boot_up_q;
    logic                 boot_done_q;

    logic [CNT_W-1:0]     eff_cnt_d;
    logic                 xfer;
    logic                 last_word;
    logic                 can_start;

    assign eff_cnt_d = (word_cnt > MAX_CNT) ? MAX_CNT : word_cnt;
    assign xfer      = in_valid & in_ready_q;
    assign last_word = (({1'b0, addr_cnt_q} + CNT_W'(1)) == cnt_q);
    assign can_start = start & ((state_q == IDLE) | (state_q == DONE) | (state_q == ERR));

`ifdef BOOT_CKSUM_EN
    logic cksum_match;
    logic boot_err_q;

    boot_cksum u_cksum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (can_start),
        .add_i   (xfer && (state_q == LOAD)),
        .data_i  (in_data),
        .match_o (cksum_match)
    );

    assign boot_err = boot_err_q;
`else
    assign boot_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_cnt_q   <= '0;
            in_ready_q   <= 1'b0;
            boot_addr_q  <= '0;
            boot_datai_q <= '0;
            boot_web_q   <= 1'b1;
            boot_up_q    <= 1'b1;
            boot_done_q  <= 1'b0;
`ifdef BOOT_CKSUM_EN
            boot_err_q   <= 1'b0;
`endif
        end else begin
            boot_web_q <= 1'b1;
            case (state_q)
                IDLE, DONE, ERR: begin
                    // Status follows the state one cycle late, so release lands two cycles after the last transfer.
                    if (state_q == DONE) begin
                        boot_up_q   <= 1'b0;
                        boot_done_q <= 1'b1;
                    end
`ifdef BOOT_CKSUM_EN
                    if (state_q == ERR) begin
                        boot_err_q <= 1'b1;
                    end
`endif
                    if (can_start) begin
                        cnt_q       <= eff_cnt_d;
                        addr_cnt_q  <= '0;
                        boot_up_q   <= 1'b1;
                        boot_done_q <= 1'b0;
`ifdef BOOT_CKSUM_EN
                        boot_err_q  <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= (eff_cnt_d == '0) ? CHECK : LOAD;
`else
                        if (eff_cnt_d == '0) begin
                            // Empty image: release the CPU straight away.
                            state_q     <= DONE;
                            boot_up_q   <= 1'b0;
                            boot_done_q <= 1'b1;
                        end else begin
                            state_q    <= LOAD;
                            in_ready_q <= 1'b1;
                        end
`endif
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        boot_web_q   <= 1'b0;
                        boot_addr_q  <= addr_cnt_q;
                        boot_datai_q <= in_data;
                        if (addr_cnt_q != LAST_ADDR) begin
                            addr_cnt_q <= addr_cnt_q + 1'b1;
                        end
                        if (last_word) begin
`ifdef BOOT_CKSUM_EN
                            state_q <= CHECK;
`else
                            state_q    <= DONE;
                            in_ready_q <= 1'b0;
`endif
                        end
                    end
                end
`ifdef BOOT_CKSUM_EN
                CHECK: begin
                    if (xfer) begin
                        in_ready_q <= 1'b0;
                        state_q    <= cksum_match ? DONE : ERR;
                    end
                end
`endif
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign boot_addr  = boot_addr_q;
    assign boot_datai = boot_datai_q;
    assign boot_web   = boot_web_q;
    assign boot_up    = boot_up_q;
    assign boot_done  = boot_done_q;

endmodule
